// File: rtl/hpg_pkg.sv
// Shared types and constants for the Hamming-distance pattern generator family.
package hpg_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDone
    } state_e;

    // Galois feedback mask for x^8+x^6+x^5+x^4+1 (right-shifting form)
    localparam logic [7:0] LFSR_TAPS         = 8'hB8;
    localparam logic [7:0] LFSR_SEED_DEFAULT = 8'hB8;

endpackage

// File: rtl/hpg_lfsr.sv
// 8-bit Galois LFSR, advancing every non-reset clock edge.
module hpg_lfsr
    import hpg_pkg::*;
#(
    parameter logic [7:0] SEED = LFSR_SEED_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] state
);

    logic [7:0] state_q;
    logic [7:0] state_d;

    always_comb begin
        state_d = state_q >> 1;
        if (state_q[0]) begin
            state_d = (state_q >> 1) ^ LFSR_TAPS;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/hamming_pattern_gen.sv
// Builds an operand b that differs from a in exactly dist bit positions, starting the
// scan at an LFSR-chosen index and flipping bits pseudo-randomly as it walks the word.
module hamming_pattern_gen
    import hpg_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DW        = $clog2(WIDTH + 1),
    parameter logic [7:0]  LFSR_SEED = LFSR_SEED_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [DW-1:0]    dist_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] b_out,
    output logic [WIDTH-1:0] mask_out,
    output logic             err
);

    localparam int unsigned   IW      = $clog2(WIDTH);
    localparam logic [DW-1:0] WIDTH_D = DW'(WIDTH);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  mask_q, mask_d;
    logic              err_q, err_d;
    logic [DW-1:0]     rem_q, rem_d;
    logic [DW-1:0]     k_q, k_d;
    logic [IW-1:0]     start_idx_q, start_idx_d;

    logic [7:0]        lfsr;
    logic              lfsr_unused;
    logic [IW-1:0]     pos;
    logic [DW-1:0]     bits_left;
    logic              flip;
    logic              last_k;
    logic              dist_bad;
    logic              dist_zero;

    hpg_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .state (lfsr)
    );

    assign lfsr_unused = ^lfsr[7:IW];

    assign pos       = start_idx_q + k_q[IW-1:0];
    assign bits_left = WIDTH_D - k_q;
    // Forcing a flip once the remaining count equals the remaining bits guarantees
    // the popcount lands exactly on the requested distance.
    assign flip      = (rem_q != '0) && ((rem_q == bits_left) || lfsr[0]);
    assign last_k    = (k_q == WIDTH_D - DW'(1));
    assign dist_bad  = (dist_in > WIDTH_D);
    assign dist_zero = (dist_in == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (dist_bad || dist_zero) ? StDone : StScan;
                end
            end
            StScan: begin
                if (last_k) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        b_out     = a_q ^ mask_q;
        mask_out  = mask_q;
        err       = err_q;
    end

    always_comb begin
        a_d         = a_q;
        mask_d      = mask_q;
        err_d       = err_q;
        rem_d       = rem_q;
        k_d         = k_q;
        start_idx_d = start_idx_q;
        if ((state_q == StIdle) && start) begin
            a_d         = a_in;
            mask_d      = '0;
            err_d       = dist_bad;
            rem_d       = dist_in;
            k_d         = '0;
            start_idx_d = lfsr[IW-1:0];
        end else if (state_q == StScan) begin
            k_d = k_q + DW'(1);
            if (flip) begin
                mask_d[pos] = 1'b1;
                rem_d       = rem_q - DW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q         <= '0;
            mask_q      <= '0;
            err_q       <= 1'b0;
            rem_q       <= '0;
            k_q         <= '0;
            start_idx_q <= '0;
        end else begin
            a_q         <= a_d;
            mask_q      <= mask_d;
            err_q       <= err_d;
            rem_q       <= rem_d;
            k_q         <= k_d;
            start_idx_q <= start_idx_d;
        end
    end

endmodule

// File: tb/tb_hamming_pattern_gen.sv
// Directed and randomised checks of hamming_pattern_gen against a transaction-level model.
module tb_hamming_pattern_gen;

    localparam int W  = 8;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  a_in = '0;
    logic [DW-1:0] dist_in = '0;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  b_out;
    logic [W-1:0]  mask_out;
    logic          err;

    int checks = 0;
    int errors = 0;

    logic [7:0]   lfsr_m = 8'hB8;
    logic         exp_active = 1'b0;
    logic [W-1:0] exp_mask = '0;
    logic [W-1:0] exp_b = '0;
    logic         exp_err = 1'b0;
    int           cur_dist = 0;
    logic [W-1:0] cur_a = '0;

    hamming_pattern_gen #(
        .WIDTH     (W),
        .DW        (DW),
        .LFSR_SEED (8'hB8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .dist_in   (dist_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .b_out     (b_out),
        .mask_out  (mask_out),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] step(input logic [7:0] s);
        return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
    endfunction

    // Whole-transaction result from the LFSR value seen on the accepting edge.
    function automatic logic [W-1:0] model_mask(input logic [7:0] l0, input int d);
        logic [7:0]   l = l0;
        logic [W-1:0] m = '0;
        int           s = int'(l0) % W;
        int           rem = d;
        if (d == 0 || d > W) return '0;
        for (int k = 0; k < W; k++) begin
            l = step(l);
            if (rem > 0 && (rem == W - k || l[0])) begin
                m[(s + k) % W] = 1'b1;
                rem--;
            end
        end
        return m;
    endfunction

    always @(posedge clk) lfsr_m <= rst_n ? step(lfsr_m) : 8'hB8;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (exp_active && out_valid) begin
                    chk("cmp_mask", mask_out, exp_mask);
                    chk("cmp_b", b_out, exp_b);
                    chk("cmp_err", err, exp_err);
                    chk("cmp_in_ready_done", in_ready, 1'b0);
                end else if (!exp_active) begin
                    chk("cmp_idle_valid", out_valid, 1'b0);
                end
            end
        end
    end

    task automatic begin_txn(input logic [W-1:0] a, input int d);
        chk("in_ready_idle", in_ready, 1'b1);
        a_in     = a;
        dist_in  = DW'(d);
        start    = 1'b1;
        cur_a    = a;
        cur_dist = d;
        exp_mask = model_mask(lfsr_m, d);
        exp_b    = a ^ exp_mask;
        exp_err  = (d > W);
        exp_active = 1'b1;
    endtask

    task automatic wait_valid();
        int lat = 1;
        @(posedge clk); #1;
        start = 1'b0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, (cur_dist == 0 || cur_dist > W) ? 1 : W + 1);
        if (cur_dist <= W) chk("popcount", $countones(mask_out), cur_dist);
        chk("b_xor", b_out, cur_a ^ mask_out);
    endtask

    task automatic finish_txn(input int hold);
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready  = 1'b0;
        exp_active = 1'b0;
        chk("valid_drop", out_valid, 1'b0);
        chk("in_ready_back", in_ready, 1'b1);
    endtask

    task automatic run_txn(input logic [W-1:0] a, input int d, input int hold);
        begin_txn(a, d);
        wait_valid();
        finish_txn(hold);
    endtask

    initial begin
        logic [W-1:0] held_b;
        logic [W-1:0] held_m;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_b", b_out, 8'h00);
        chk("rst_mask", mask_out, 8'h00);
        chk("rst_err", err, 1'b0);
        rst_n = 1'b1;

        // LFSR is still at the seed here, so the result is known by hand.
        begin_txn(8'h00, 1);
        wait_valid();
        chk("pin_mask_seed", mask_out, 8'h04);
        finish_txn(0);

        begin_txn(8'hA5, 0);
        wait_valid();
        chk("t1_b", b_out, 8'hA5);
        chk("t1_mask", mask_out, 8'h00);
        chk("t1_err", err, 1'b0);
        finish_txn(1);

        begin_txn(8'h3C, 8);
        wait_valid();
        chk("t2_b", b_out, 8'hC3);
        chk("t2_mask", mask_out, 8'hFF);
        chk("t2_err", err, 1'b0);
        finish_txn(2);

        begin_txn(8'h5A, 9);
        wait_valid();
        chk("t3_b", b_out, 8'h5A);
        chk("t3_mask", mask_out, 8'h00);
        chk("t3_err", err, 1'b1);
        finish_txn(0);

        for (int n = 0; n < 500; n++) begin
            run_txn(W'($urandom_range(0, 255)), int'($urandom_range(1, 8)),
                    int'($urandom_range(0, 3)));
        end

        begin_txn(8'h96, 3);
        wait_valid();
        held_b = b_out;
        held_m = mask_out;
        for (int i = 0; i < 6; i++) begin
            start = (i % 2 == 0);
            @(posedge clk); #1;
            chk("t5_hold_valid", out_valid, 1'b1);
            chk("t5_hold_b", b_out, held_b);
            chk("t5_hold_mask", mask_out, held_m);
            chk("t5_in_ready", in_ready, 1'b0);
        end
        start = 1'b0;
        finish_txn(0);
        run_txn(8'h01, 4, 0);

        begin_txn(8'h77, 5);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n      = 1'b0;
        exp_active = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("t6_valid", out_valid, 1'b0);
        chk("t6_in_ready", in_ready, 1'b1);
        chk("t6_b", b_out, 8'h00);
        chk("t6_mask", mask_out, 8'h00);
        chk("t6_err", err, 1'b0);
        chk("t6_lfsr", dut.u_lfsr.state, 8'hB8);
        begin_txn(8'h0F, 2);
        wait_valid();
        chk("pin_mask_reset", mask_out, 8'h0C);
        chk("t6_b_after", b_out, 8'h03);
        finish_txn(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
